// File: rtl/btb_update_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : btb_update_scheduler_if                                         |
// | Purpose  : Requester, flush and BTB-write signal bundle for the scheduler. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface btb_update_scheduler_if #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              ihit;
   logic              req0_valid;
   logic [WORD_W-1:0] req0_pc;
   logic [WORD_W-1:0] req0_target;
   logic              req0_taken;
   logic              req0_ready;
   logic              req1_valid;
   logic [WORD_W-1:0] req1_pc;
   logic [WORD_W-1:0] req1_target;
   logic              req1_taken;
   logic              req1_ready;
   logic              flush_req;
   logic              flush_busy;
   logic              upd_valid;
   logic [WORD_W-1:0] upd_pc;
   logic [WORD_W-1:0] upd_target;
   logic              upd_taken;
   logic [CNT_W-1:0]  fifo_count;

   // master: branch-resolution / BTB environment; slave: the scheduler itself
   modport master (
      output ihit,
      output req0_valid, req0_pc, req0_target, req0_taken,
      output req1_valid, req1_pc, req1_target, req1_taken,
      output flush_req,
      input  req0_ready, req1_ready, flush_busy,
      input  upd_valid, upd_pc, upd_target, upd_taken, fifo_count
   );

   modport slave (
      input  ihit,
      input  req0_valid, req0_pc, req0_target, req0_taken,
      input  req1_valid, req1_pc, req1_target, req1_taken,
      input  flush_req,
      output req0_ready, req1_ready, flush_busy,
      output upd_valid, upd_pc, upd_target, upd_taken, fifo_count
   );
endinterface
`default_nettype wire

// File: rtl/btb_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : btb_update_scheduler                                            |
// | Purpose  : Two-requester BTB update FIFO drained on ihit, plus a full-     |
// |            table invalidate sweep on flush. BTB_UPD_STATS_EN adds counters.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module btb_update_scheduler #(
   parameter int WORD_W      = 32,
   parameter int DEPTH       = 4,
   parameter int BUFFER_SIZE = 256,
   parameter int IDX_SIZE    = 8
) (
   input  logic CLK,
   input  logic RST,
   btb_update_scheduler_if.slave bus
`ifdef BTB_UPD_STATS_EN
   ,
   output logic [15:0] stat_updates,
   output logic [15:0] stat_stalls
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]    C_DEPTH    = CNT_W'(DEPTH);
   localparam logic [IDX_SIZE-1:0] C_LAST_IDX = IDX_SIZE'(BUFFER_SIZE - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_SWEEP = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [WORD_W-1:0]   r_pc_mem  [DEPTH];
   logic [WORD_W-1:0]   r_tgt_mem [DEPTH];
   logic [DEPTH-1:0]    r_tk_mem;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [IDX_SIZE-1:0] r_idx;

   logic                w_sweep;
   logic [CNT_W-1:0]    w_free;
   logic                w_ready0;
   logic                w_ready1;
   logic                w_push0;
   logic                w_push1;
   logic                w_fifo_valid;
   logic                w_pop;
   logic                w_flush;
   logic                w_sweep_last;
   logic [CNT_W-1:0]    w_count_next;
   logic [PTR_W-1:0]    w_wr_ptr1;
   logic [WORD_W-1:0]   w_sweep_pc;

   assign w_sweep      = (r_state == ST_SWEEP);
   assign w_free       = C_DEPTH - r_count;
   assign w_ready0     = !w_sweep && (w_free != '0);
   // req1 may take the last slot only when req0 is not competing for it
   assign w_ready1     = !w_sweep && ((w_free >= CNT_W'(2)) ||
                                      ((w_free == CNT_W'(1)) && !bus.req0_valid));
   assign w_push0      = bus.req0_valid && w_ready0;
   assign w_push1      = bus.req1_valid && w_ready1;
   assign w_fifo_valid = !w_sweep && (r_count != '0);
   assign w_pop        = w_fifo_valid && bus.ihit;
   assign w_flush      = bus.flush_req && !w_sweep;
   assign w_sweep_last = w_sweep && bus.ihit && (r_idx == C_LAST_IDX);
   assign w_count_next = r_count + CNT_W'(w_push0) + CNT_W'(w_push1) - CNT_W'(w_pop);
   assign w_wr_ptr1    = r_wr_ptr + PTR_W'(w_push0);
   assign w_sweep_pc   = WORD_W'({r_idx, 2'b00});

   assign bus.req0_ready = w_ready0;
   assign bus.req1_ready = w_ready1;
   assign bus.flush_busy = w_sweep;
   assign bus.fifo_count = r_count;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      bus.upd_valid  = 1'b0;
      bus.upd_pc     = r_pc_mem[r_rd_ptr];
      bus.upd_target = r_tgt_mem[r_rd_ptr];
      bus.upd_taken  = r_tk_mem[r_rd_ptr];
      case (r_state)
         ST_IDLE, ST_DRAIN: begin
            bus.upd_valid = w_fifo_valid;
            if (w_flush) begin
               w_state_next = ST_SWEEP;
            end else if (w_count_next != '0) begin
               w_state_next = ST_DRAIN;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_SWEEP: begin
            bus.upd_valid  = 1'b1;
            bus.upd_pc     = w_sweep_pc;
            bus.upd_target = '0;
            bus.upd_taken  = 1'b0;
            if (w_sweep_last) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Flush drops every queued entry, including anything pushed in the same cycle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_push0) + PTR_W'(w_push1);
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_idx <= '0;
      end else if (w_sweep && bus.ihit) begin
         r_idx <= w_sweep_last ? '0 : (r_idx + IDX_SIZE'(1));
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push0) begin
         r_pc_mem[r_wr_ptr]  <= bus.req0_pc;
         r_tgt_mem[r_wr_ptr] <= bus.req0_target;
         r_tk_mem[r_wr_ptr]  <= bus.req0_taken;
      end
      if (w_push1) begin
         r_pc_mem[w_wr_ptr1]  <= bus.req1_pc;
         r_tgt_mem[w_wr_ptr1] <= bus.req1_target;
         r_tk_mem[w_wr_ptr1]  <= bus.req1_taken;
      end
   end

`ifdef BTB_UPD_STATS_EN
   logic [15:0] r_stat_updates;
   logic [15:0] r_stat_stalls;
   logic        w_stall;

   assign w_stall = (bus.req0_valid && !w_ready0) || (bus.req1_valid && !w_ready1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_stat_updates <= '0;
         r_stat_stalls  <= '0;
      end else if (bus.flush_req) begin
         r_stat_updates <= '0;
         r_stat_stalls  <= '0;
      end else begin
         if (w_pop && (r_stat_updates != 16'hFFFF)) begin
            r_stat_updates <= r_stat_updates + 16'd1;
         end
         if (w_stall && (r_stat_stalls != 16'hFFFF)) begin
            r_stat_stalls <= r_stat_stalls + 16'd1;
         end
      end
   end

   assign stat_updates = r_stat_updates;
   assign stat_stalls  = r_stat_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_btb_update_scheduler                                         |
// | Purpose  : Directed and randomized bench against a queue-based model.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_btb_update_scheduler;

   logic CLK;
   logic RST;
   btb_update_scheduler_if #(.WORD_W(32), .DEPTH(4)) bus ();
`ifdef BTB_UPD_STATS_EN
   logic [15:0] stat_updates;
   logic [15:0] stat_stalls;
`endif

   btb_update_scheduler #(
      .WORD_W(32), .DEPTH(4), .BUFFER_SIZE(256), .IDX_SIZE(8)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
`ifdef BTB_UPD_STATS_EN
      , .stat_updates(stat_updates)
      , .stat_stalls(stat_stalls)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        tk;
   } ent_t;

   ent_t mq[$];
   bit   m_sweep;
   int   m_idx;
   int   m_su;
   int   m_ss;

   logic        e_r0, e_r1, e_valid, e_tk, e_busy;
   logic [31:0] e_pc, e_tgt;
   logic [2:0]  e_count;

   function automatic void model_reset();
      mq.delete();
      m_sweep = 1'b0;
      m_idx   = 0;
      m_su    = 0;
      m_ss    = 0;
   endfunction

   // Expected outputs for the current cycle from the model state and present inputs
   function automatic void model_expect();
      int free;
      e_pc = '0; e_tgt = '0; e_tk = 1'b0;
      if (m_sweep) begin
         e_r0 = 1'b0; e_r1 = 1'b0; e_valid = 1'b1; e_busy = 1'b1; e_count = '0;
         e_pc = 32'(m_idx * 4);
      end else begin
         free    = 4 - mq.size();
         e_r0    = (free >= 1);
         e_r1    = (free >= 2) || (free == 1 && !bus.req0_valid);
         e_valid = (mq.size() > 0);
         e_busy  = 1'b0;
         e_count = 3'(mq.size());
         if (e_valid) begin
            e_pc = mq[0].pc; e_tgt = mq[0].tgt; e_tk = mq[0].tk;
         end
      end
   endfunction

   function automatic void model_commit();
      bit   stall;
      ent_t e;
      stall = (bus.req0_valid && !e_r0) || (bus.req1_valid && !e_r1);
      if (m_sweep) begin
         if (bus.ihit) begin
            m_idx++;
            if (m_idx == 256) begin
               m_sweep = 1'b0;
               m_idx   = 0;
            end
         end
      end else if (bus.flush_req) begin
         mq.delete();
         m_sweep = 1'b1;
         m_idx   = 0;
      end else begin
         if (mq.size() > 0 && bus.ihit) begin
            void'(mq.pop_front());
            if (m_su < 65535) m_su++;
         end
         if (bus.req0_valid && e_r0) begin
            e.pc = bus.req0_pc; e.tgt = bus.req0_target; e.tk = bus.req0_taken;
            mq.push_back(e);
         end
         if (bus.req1_valid && e_r1) begin
            e.pc = bus.req1_pc; e.tgt = bus.req1_target; e.tk = bus.req1_taken;
            mq.push_back(e);
         end
      end
      if (bus.flush_req) begin
         m_su = 0;
         m_ss = 0;
      end else if (stall && m_ss < 65535) begin
         m_ss++;
      end
   endfunction

   task automatic set_req0(input logic v, input logic [31:0] p, input logic [31:0] t, input logic k);
      bus.req0_valid = v; bus.req0_pc = p; bus.req0_target = t; bus.req0_taken = k;
   endtask

   task automatic set_req1(input logic v, input logic [31:0] p, input logic [31:0] t, input logic k);
      bus.req1_valid = v; bus.req1_pc = p; bus.req1_target = t; bus.req1_taken = k;
   endtask

   task automatic set_ctl(input logic ih, input logic fl);
      bus.ihit = ih; bus.flush_req = fl;
   endtask

   task automatic idle_inputs(input logic ih);
      set_req0(1'b0, '0, '0, 1'b0);
      set_req1(1'b0, '0, '0, 1'b0);
      set_ctl(ih, 1'b0);
   endtask

   // Commit the model for this cycle and move to the next falling edge
   task automatic advance();
      model_commit();
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      idle_inputs(1'b0);
      model_reset();
      repeat (3) @(negedge CLK);
      #1;
      n_vec++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.fifo_count); end
      n_vec++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL reset_upd_valid got=%b exp=0", bus.upd_valid); end
      n_vec++; if (bus.flush_busy !== 1'b0) begin n_err++; $display("FAIL reset_flush_busy got=%b exp=0", bus.flush_busy); end
      @(negedge CLK);
      RST = 1'b0;
      #1;
      n_vec++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL reset_req0_ready got=%b exp=1", bus.req0_ready); end
      n_vec++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL reset_req1_ready got=%b exp=1", bus.req1_ready); end
`ifdef BTB_UPD_STATS_EN
      n_vec++; if (stat_updates !== 16'd0 || stat_stalls !== 16'd0) begin
         n_err++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_updates, stat_stalls); end
`endif
      @(negedge CLK);
   endtask

   task automatic test_single_push();
      set_req0(1'b1, 32'h100, 32'h80, 1'b1);
      set_ctl(1'b1, 1'b0);
      #1; model_expect();
      n_vec++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got=%b exp=1", bus.req0_ready); end
      n_vec++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL single_no_early got=%b exp=0", bus.upd_valid); end
      advance();
      idle_inputs(1'b1);
      #1; model_expect();
      n_vec++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h100 || bus.upd_target !== 32'h80 || bus.upd_taken !== 1'b1) begin
         n_err++; $display("FAIL single_upd got=%b/%h/%h/%b exp=1/00000100/00000080/1", bus.upd_valid, bus.upd_pc, bus.upd_target, bus.upd_taken); end
      n_vec++; if (bus.fifo_count !== 3'd1) begin n_err++; $display("FAIL single_count1 got=%0d exp=1", bus.fifo_count); end
      advance();
      #1; model_expect();
      n_vec++; if (bus.fifo_count !== 3'd0 || bus.upd_valid !== 1'b0) begin
         n_err++; $display("FAIL single_drained got=%0d/%b exp=0/0", bus.fifo_count, bus.upd_valid); end
      advance();
   endtask

   task automatic test_arbitration();
      logic [31:0] got[$];
      logic [31:0] exp_seq[5];
      exp_seq = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h300};
      for (int i = 0; i < 3; i++) begin
         set_req0(1'b1, 32'h200 + 32'(i * 4), 32'h1000 + 32'(i), 1'(i));
         set_req1(1'b0, '0, '0, 1'b0);
         set_ctl(1'b0, 1'b0);
         #1; model_expect();
         advance();
      end
      set_req0(1'b1, 32'h20C, 32'h2000, 1'b0);
      set_req1(1'b1, 32'h300, 32'h3000, 1'b1);
      #1; model_expect();
      n_vec++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         n_err++; $display("FAIL arb_free1 got=%b/%b exp=1/0", bus.req0_ready, bus.req1_ready); end
      advance();
      set_req0(1'b0, '0, '0, 1'b0);
      bus.ihit = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1; model_expect();
         if (bus.upd_valid === 1'b1) got.push_back(bus.upd_pc);
         n_vec++; if (bus.upd_valid !== e_valid || (e_valid && bus.upd_pc !== e_pc)) begin
            n_err++; $display("FAIL arb_drain cyc=%0d got=%b/%h exp=%b/%h", i, bus.upd_valid, bus.upd_pc, e_valid, e_pc); end
         advance();
         if (bus.req1_valid && e_r1) set_req1(1'b0, '0, '0, 1'b0);
      end
      n_vec++; if (got.size() !== 5) begin n_err++; $display("FAIL arb_pop_count got=%0d exp=5", got.size()); end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         n_vec++; if (got[i] !== exp_seq[i]) begin n_err++; $display("FAIL arb_order idx=%0d got=%h exp=%h", i, got[i], exp_seq[i]); end
      end
   endtask

   task automatic test_fill_drain();
      logic [31:0] got[$];
      set_ctl(1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         set_req0(1'b1, 32'h400 + 32'(i * 8), 32'h4000, 1'b1);
         set_req1(1'b1, 32'h404 + 32'(i * 8), 32'h4004, 1'b0);
         #1; model_expect();
         advance();
      end
      set_req0(1'b1, 32'h500, '0, 1'b0);
      set_req1(1'b1, 32'h504, '0, 1'b0);
      #1; model_expect();
      n_vec++; if (bus.fifo_count !== 3'd4) begin n_err++; $display("FAIL fill_count got=%0d exp=4", bus.fifo_count); end
      n_vec++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         n_err++; $display("FAIL fill_readies got=%b/%b exp=0/0", bus.req0_ready, bus.req1_ready); end
      advance();
      idle_inputs(1'b1);
      for (int i = 0; i < 4; i++) begin
         #1; model_expect();
         if (bus.upd_valid === 1'b1) got.push_back(bus.upd_pc);
         advance();
      end
      n_vec++; if (got.size() !== 4) begin n_err++; $display("FAIL fill_pops got=%0d exp=4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_vec++; if (got[i] !== 32'h400 + 32'(i * 4)) begin
            n_err++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, got[i], 32'h400 + 32'(i * 4)); end
      end
      #1; model_expect();
      n_vec++; if (bus.fifo_count !== 3'd0 || bus.upd_valid !== 1'b0) begin
         n_err++; $display("FAIL fill_idle got=%0d/%b exp=0/0", bus.fifo_count, bus.upd_valid); end
      advance();
   endtask

   task automatic test_flush_sweep();
      idle_inputs(1'b0);
      for (int i = 0; i < 3; i++) begin
         set_req0(1'b1, 32'h600 + 32'(i * 4), 32'h6000, 1'b1);
         #1; model_expect();
         advance();
      end
      idle_inputs(1'b0);
      set_ctl(1'b0, 1'b1);
      #1; model_expect();
      n_vec++; if (bus.fifo_count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got=%0d exp=3", bus.fifo_count); end
      advance();
      set_ctl(1'b1, 1'b0);
      #1;
      n_vec++; if (bus.fifo_count !== 3'd0 || bus.flush_busy !== 1'b1) begin
         n_err++; $display("FAIL flush_enter got=%0d/%b exp=0/1", bus.fifo_count, bus.flush_busy); end
      for (int i = 0; i < 256; i++) begin
         #1; model_expect();
         n_vec++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'(i * 4) || bus.upd_taken !== 1'b0 ||
                      bus.upd_target !== 32'h0 || bus.flush_busy !== 1'b1 || bus.req0_ready !== 1'b0) begin
            n_err++; $display("FAIL sweep_write i=%0d got=%b/%h/%b/%h/%b exp=1/%h/0/0/1", i, bus.upd_valid,
                              bus.upd_pc, bus.upd_taken, bus.upd_target, bus.flush_busy, 32'(i * 4)); end
         advance();
         #1;
      end
      model_expect();
      n_vec++; if (bus.flush_busy !== 1'b0 || bus.upd_valid !== 1'b0) begin
         n_err++; $display("FAIL sweep_exit got=%b/%b exp=0/0", bus.flush_busy, bus.upd_valid); end
      advance();
   endtask

   task automatic test_random();
      for (int c = 0; c < 1200; c++) begin
         set_req0(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
         set_req1(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
         set_ctl(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 149) == 0));
         #1; model_expect();
         n_vec++; if (bus.req0_ready !== e_r0 || bus.req1_ready !== e_r1) begin
            n_err++; $display("FAIL rnd_ready cyc=%0d got=%b/%b exp=%b/%b", c, bus.req0_ready, bus.req1_ready, e_r0, e_r1); end
         n_vec++; if (bus.upd_valid !== e_valid || bus.flush_busy !== e_busy || bus.fifo_count !== e_count) begin
            n_err++; $display("FAIL rnd_status cyc=%0d got=%b/%b/%0d exp=%b/%b/%0d", c, bus.upd_valid,
                              bus.flush_busy, bus.fifo_count, e_valid, e_busy, e_count); end
         if (e_valid) begin
            n_vec++; if (bus.upd_pc !== e_pc || bus.upd_target !== e_tgt || bus.upd_taken !== e_tk) begin
               n_err++; $display("FAIL rnd_data cyc=%0d got=%h/%h/%b exp=%h/%h/%b", c, bus.upd_pc,
                                 bus.upd_target, bus.upd_taken, e_pc, e_tgt, e_tk); end
         end
`ifdef BTB_UPD_STATS_EN
         n_vec++; if (stat_updates !== 16'(m_su) || stat_stalls !== 16'(m_ss)) begin
            n_err++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", c, stat_updates, stat_stalls, m_su, m_ss); end
`endif
         advance();
      end
      idle_inputs(1'b1);
      for (int c = 0; c < 300 && (m_sweep || mq.size() > 0); c++) begin
         #1; model_expect();
         advance();
      end
      #1;
      n_vec++; if (bus.flush_busy !== 1'b0 || bus.fifo_count !== 3'd0) begin
         n_err++; $display("FAIL rnd_settle got=%b/%0d exp=0/0", bus.flush_busy, bus.fifo_count); end
   endtask

   task automatic test_reset_mid_sweep();
      idle_inputs(1'b1);
      bus.flush_req = 1'b1;
      #1; model_expect();
      advance();
      bus.flush_req = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #1; model_expect();
         advance();
      end
      #1;
      n_vec++; if (bus.upd_pc !== 32'd400 || bus.flush_busy !== 1'b1) begin
         n_err++; $display("FAIL midsweep_idx got=%h/%b exp=00000190/1", bus.upd_pc, bus.flush_busy); end
      #2 RST = 1'b1;
      #1;
      n_vec++; if (bus.upd_valid !== 1'b0 || bus.flush_busy !== 1'b0) begin
         n_err++; $display("FAIL async_reset got=%b/%b exp=0/0", bus.upd_valid, bus.flush_busy); end
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      idle_inputs(1'b0);
      bus.flush_req = 1'b1;
      #1; model_expect();
      advance();
      idle_inputs(1'b1);
      #1;
      n_vec++; if (bus.upd_pc !== 32'h0 || bus.flush_busy !== 1'b1 || bus.upd_valid !== 1'b1) begin
         n_err++; $display("FAIL resweep_start got=%h/%b/%b exp=00000000/1/1", bus.upd_pc, bus.flush_busy, bus.upd_valid); end
      for (int i = 0; i < 256; i++) begin
         #1; model_expect();
         advance();
      end
      #1;
      n_vec++; if (bus.flush_busy !== 1'b0) begin n_err++; $display("FAIL resweep_end got=%b exp=0", bus.flush_busy); end
   endtask

`ifdef BTB_UPD_STATS_EN
   task automatic test_stats();
      idle_inputs(1'b1);
      bus.flush_req = 1'b1;
      #1; model_expect(); advance();
      bus.flush_req = 1'b0;
      for (int i = 0; i < 256; i++) begin #1; model_expect(); advance(); end
      bus.ihit = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_req0(1'b1, 32'h700 + 32'(i * 8), '0, 1'b1);
         set_req1(1'b1, 32'h704 + 32'(i * 8), '0, 1'b1);
         #1; model_expect(); advance();
      end
      set_req1(1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin set_req0(1'b1, 32'h800, '0, 1'b0); #1; model_expect(); advance(); end
      idle_inputs(1'b1);
      for (int i = 0; i < 4; i++) begin #1; model_expect(); advance(); end
      set_req0(1'b1, 32'h900, '0, 1'b1);
      #1; model_expect(); advance();
      idle_inputs(1'b1);
      #1; model_expect(); advance();
      #1;
      n_vec++; if (stat_updates !== 16'd5 || stat_stalls !== 16'd3) begin
         n_err++; $display("FAIL stats_counts got=%0d/%0d exp=5/3", stat_updates, stat_stalls); end
      bus.flush_req = 1'b1;
      model_expect(); advance();
      bus.flush_req = 1'b0;
      #1;
      n_vec++; if (stat_updates !== 16'd0 || stat_stalls !== 16'd0) begin
         n_err++; $display("FAIL stats_flush got=%0d/%0d exp=0/0", stat_updates, stat_stalls); end
      for (int i = 0; i < 256; i++) begin #1; model_expect(); advance(); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_push();
      test_arbitration();
      test_fill_drain();
      test_flush_sweep();
      test_random();
      test_reset_mid_sweep();
`ifdef BTB_UPD_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
